eeprom_save_ram: RTL

Backing store and access arbiter for the serial-EEPROM save memory (24C01/24C02 class) used by Bandai-style mappers. It sits directly downstream of the EEPROM protocol engine and serves that engine's byte-wide `ram_read`/`ram_write`/`ram_done` requests from an internal byte array. A second host port lets the frontend load and store the save image. The block also keeps a dirty flag for autosave.

---
 rtl/eeprom_save_ram.sv | 113 +++++++++++
 1 files changed

// File: rtl/eeprom_save_ram.sv
// Byte-array save store for a serial-EEPROM protocol engine, shared with a host load/store port.
// The host wins ties in IDLE; the dirty flag tracks EEPROM-side writes for autosave.
module eeprom_save_ram #(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        data_to_ram,
    input  logic              ram_read,
    input  logic              ram_write,
    output logic [7:0]        data_from_ram,
    output logic              ram_done,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              host_ack,
    output logic              dirty,
    input  logic              dirty_clr
);

    typedef enum logic [2:0] {
        IDLE,
        EE_RD,
        EE_DONE,
        HOST_RD,
        HOST_ACK
    } state_t;

    localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        mem [1 << ADDR_W];
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        cnt;
    logic              acc_ok;
    logic              host_go;
    logic              ee_go;
    logic              lat_hit;

    // Handshake: ram_read/ram_write are levels answered by ram_done, which stays high
    // until both requests drop; host_req is held until the one-cycle host_ack pulse.
    // A still-visible ram_done or host_ack blocks acceptance so a held request is
    // never served twice and accesses are separated by at least one IDLE cycle.
    always_comb begin
        acc_ok    = (state == IDLE) && !ram_done && !host_ack;
        host_go   = acc_ok && host_req;
        ee_go     = acc_ok && !host_req && (ram_read || ram_write);
        lat_hit   = (cnt == CNT_LAST);
        state_nxt = state;
        case (state)
            IDLE: begin
                if (host_go) begin
                    state_nxt = host_we ? HOST_ACK : HOST_RD;
                end else if (ee_go) begin
                    state_nxt = ram_write ? EE_DONE : EE_RD;
                end
            end
            EE_RD:    if (lat_hit) state_nxt = EE_DONE;
            EE_DONE:  if (!ram_read && !ram_write) state_nxt = IDLE;
            HOST_RD:  if (lat_hit) state_nxt = HOST_ACK;
            HOST_ACK: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Array contents survive reset; only the accept edge writes.
    always_ff @(posedge clk) begin
        if (!reset && host_go && host_we) begin
            mem[host_addr] <= host_wdata;
        end else if (!reset && ee_go && ram_write) begin
            mem[ram_addr] <= data_to_ram;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q        <= '0;
            cnt           <= '0;
            data_from_ram <= '0;
            host_rdata    <= '0;
            ram_done      <= 1'b0;
            host_ack      <= 1'b0;
            dirty         <= 1'b0;
        end else begin
            if (host_go)    addr_q <= host_addr;
            else if (ee_go) addr_q <= ram_addr;

            if (state == EE_RD || state == HOST_RD) cnt <= cnt + 2'd1;
            else                                    cnt <= '0;

            if (state == EE_RD && lat_hit)   data_from_ram <= mem[addr_q];
            if (state == HOST_RD && lat_hit) host_rdata    <= mem[addr_q];

            ram_done <= (state == EE_DONE) && (ram_read || ram_write);
            host_ack <= (state == HOST_ACK);

            // Set beats clear when both land on the same edge.
            if (ee_go && ram_write) dirty <= 1'b1;
            else if (dirty_clr)     dirty <= 1'b0;
        end
    end

endmodule
